apb_master_nslv: RTL

APB_MASTER_NSLV -- requirements
Module: apb_master_nslv

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_slv_decode.sv | 38 +++
 rtl/apb_master_nslv.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - FSM state encoding and default widths for the APB master
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam int APB_ADDR_W  = 12;
    localparam int APB_DATA_W  = 32;
    localparam int APB_NUM_SLV = 4;
    localparam int APB_TIMEOUT = 16;

endpackage

// File: rtl/apb_slv_decode.sv
// rtl/apb_slv_decode.sv - combinational address to one-hot slave select plus decode error
module apb_slv_decode
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int NUM_SLV = APB_NUM_SLV
) (
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [NUM_SLV-1:0] sel_o,
    output logic               err_o
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    logic [IDX_W-1:0] idx;
    logic             unused_addr;

    // Only the top address bits pick the slave; the rest travel on PADDR.
    assign unused_addr = ^addr_i;

    generate
        if (NUM_SLV == 1) begin : g_single
            assign idx = '0;
        end else begin : g_multi
            assign idx = addr_i[ADDR_W-1 -: IDX_W];
        end
    endgenerate

    // Indices past the last slave (non power-of-two counts) select nobody.
    always_comb begin
        sel_o = '0;
        err_o = (int'(idx) >= NUM_SLV);
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_o[i] = (int'(idx) == i);
        end
    end

endmodule

// File: rtl/apb_master_nslv.sv
// rtl/apb_master_nslv.sv - APB master with N slave selects; APB_TIMEOUT_EN adds an ACCESS timeout
module apb_master_nslv
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int NUM_SLV = APB_NUM_SLV,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic                      PCLK,
    input  logic                      PRST,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    input  logic [DATA_W/8-1:0]       cmd_strb,
    output logic                      rsp_valid,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA
);

    apb_state_e            state_q;
    logic [NUM_SLV-1:0]    psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_W-1:0]     paddr_q;
    logic [DATA_W-1:0]     pwdata_q;
    logic [DATA_W/8-1:0]   pstrb_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_W-1:0]     rsp_rdata_q;

    logic [NUM_SLV-1:0]    dec_sel;
    logic                  dec_err;
    logic                  accept;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  tmo_hit;

    apb_slv_decode #(
        .ADDR_W  (ADDR_W),
        .NUM_SLV (NUM_SLV)
    ) u_decode (
        .addr_i (cmd_addr),
        .sel_o  (dec_sel),
        .err_o  (dec_err)
    );

    assign cmd_ready = (state_q == IDLE) && PRST;
    assign accept    = cmd_valid && cmd_ready;

    // Observe only the slave whose PSEL is raised; the others are don't-care.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (psel_q[i]) begin
                sel_ready = sel_ready | PREADY[i];
                sel_err   = sel_err   | PSLVERR[i];
                sel_rdata = sel_rdata | PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit = (state_q == ACCESS) && !sel_ready && (tmo_q == TMO_W'(TIMEOUT - 1));

    // Count stalled ACCESS cycles, restarting on every SETUP.
    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            tmo_q <= '0;
        end else if (state_q == SETUP) begin
            tmo_q <= '0;
        end else if (state_q == ACCESS && !sel_ready) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign tmo_hit        = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Transfer FSM; every APB and response output is a register here.
    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (dec_err) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            psel_q   <= dec_sel;
                            pwrite_q <= cmd_write;
                            paddr_q  <= cmd_addr;
                            pwdata_q <= cmd_write ? cmd_wdata : '0;
                            pstrb_q  <= cmd_write ? cmd_strb : '0;
                            state_q  <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready || tmo_hit) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= sel_ready ? sel_err : 1'b1;
                        rsp_rdata_q <= (sel_ready && !pwrite_q) ? sel_rdata : '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
